// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_IDLE
   } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous line; resets to the idle-high level.
module uart_sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], i_d};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver with a one-byte valid/ready holding register, frame-error and overrun pulses.
module uart_rx_stream
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx_serial,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_rx_busy
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic rx_sync;

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic             deliver;

   uart_sync2 u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rx_serial),
      .o_q     (rx_sync)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      deliver     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_sync) begin
               bit_idx_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d   = '0;
               state_d = rx_sync ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               shift_d = {rx_sync, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (rx_sync) begin
                  deliver = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_sync) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // A delivery coinciding with a handshake reloads the register, so valid never drops.
   always_comb begin
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      busy_d     = (state_d != ST_IDLE);

      if (rx_valid_q && i_rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (deliver) begin
         if (!rx_valid_q || i_rx_ready) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign o_rx_byte   = rx_byte_q;
   assign o_rx_valid  = rx_valid_q;
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;
   assign o_rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream: directed scenarios plus randomized frame bursts.
module tb_uart_rx_stream;

   localparam int unsigned CPB  = 217;
   localparam int unsigned HALF = (CPB - 1) / 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_serial = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] o_rx_byte;
   logic       o_rx_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_rx_busy;

   always #5 clk = ~clk;

   uart_rx_stream #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_rx_serial (rx_serial),
      .o_rx_byte   (o_rx_byte),
      .o_rx_valid  (o_rx_valid),
      .i_rx_ready  (rx_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_rx_busy   (o_rx_busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];
   int exp_ferr = 0, seen_ferr = 0;
   int exp_ovr  = 0, seen_ovr  = 0;
   bit ready_mode = 1'b1;   // consumer always ready for the whole frame sequence
   bit held_full  = 1'b0;   // reference holding register occupied (stalled consumer)

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: a stalled consumer keeps the first good byte, later good bytes are overruns.
   task automatic model_frame(input logic [7:0] b, input logic stop_bit);
      if (!stop_bit) begin
         exp_ferr++;
      end else if (ready_mode || !held_full) begin
         exp_q.push_back(b);
         if (!ready_mode) held_full = 1'b1;
      end else begin
         exp_ovr++;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit do_model,
                             input int unsigned low_tail);
      if (do_model) model_frame(b, stop_bit);
      @(negedge clk);
      rx_serial = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         rx_serial = b[i];
      end
      repeat (CPB) @(negedge clk);
      rx_serial = stop_bit;
      repeat (CPB) @(negedge clk);
      if (!stop_bit) repeat (low_tail * CPB) @(negedge clk);
      rx_serial = 1'b1;
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      held_full  = 1'b0;
      ready_mode = 1'b1;
   endtask

   task automatic end_check(input string name);
      repeat (20) @(negedge clk);
      #1;
      check({name, "_frame_err_count"}, seen_ferr, exp_ferr);
      check({name, "_overrun_count"}, seen_ovr, exp_ovr);
      check({name, "_bytes_outstanding"}, exp_q.size(), 0);
      check({name, "_busy"}, o_rx_busy, 0);
      check({name, "_valid"}, o_rx_valid, 0);
   endtask

   // Monitor: samples 1 time unit after each falling edge, after stimulus has settled.
   initial begin
      logic       last_valid = 1'b0;
      logic       last_hs    = 1'b0;
      logic [7:0] last_byte  = '0;
      forever begin
         @(negedge clk);
         #1;
         if (o_frame_err) seen_ferr++;
         if (o_overrun) seen_ovr++;
         if (last_valid && !last_hs && o_rx_valid) check("byte_stable", o_rx_byte, last_byte);
         if (o_rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no delivery", o_rx_byte);
            end else begin
               check("rx_byte", o_rx_byte, exp_q.pop_front());
            end
         end
         last_valid = o_rx_valid;
         last_hs    = o_rx_valid && rx_ready;
         last_byte  = o_rx_byte;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rb;
      logic       rs;
      logic [7:0] c3 = 8'hC3;

      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("reset_byte", o_rx_byte, 8'h00);
      check("reset_valid", o_rx_valid, 0);
      check("reset_frame_err", o_frame_err, 0);
      check("reset_overrun", o_overrun, 0);
      check("reset_busy", o_rx_busy, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      rx_ready = 1'b1;
      repeat (10) @(negedge clk);

      // Single byte, consumer ready: valid is a one-cycle pulse.
      fork
         send_frame(8'h3F, 1'b1, 1'b1, 0);
         begin
            int k = 0;
            while (k < int'(CPB * 12)) begin
               @(negedge clk);
               #1;
               if (o_rx_valid) break;
               k++;
            end
            check("valid_seen_3f", int'(k < int'(CPB * 12)), 1);
            @(negedge clk);
            #1;
            check("valid_one_cycle", o_rx_valid, 0);
         end
      join
      end_check("byte_3f");

      // Stalled consumer: second byte overruns.
      ready_mode = 1'b0;
      rx_ready   = 1'b0;
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      repeat (5) @(negedge clk);
      send_frame(8'h5A, 1'b1, 1'b1, 0);
      repeat (10) @(negedge clk);
      #1;
      check("overrun_hold_byte", o_rx_byte, 8'hA5);
      check("overrun_hold_valid", o_rx_valid, 1);
      check("overrun_pulses", seen_ovr, exp_ovr);
      drain();
      end_check("overrun");

      // Bad stop bit followed by a long break, then a good frame.
      send_frame(8'hFF, 1'b0, 1'b1, 20);
      repeat (30) @(negedge clk);
      send_frame(8'h00, 1'b1, 1'b1, 0);
      end_check("frame_err");

      // Short low glitch from idle.
      @(negedge clk);
      rx_serial = 1'b0;
      repeat (50) @(negedge clk);
      rx_serial = 1'b1;
      repeat (200) @(negedge clk);
      end_check("glitch");

      // Reset in the middle of data bit 4, then a clean frame.
      @(negedge clk);
      rx_serial = 1'b0;
      for (int i = 0; i < 5; i++) begin
         repeat (CPB) @(negedge clk);
         rx_serial = c3[i];
      end
      repeat (CPB / 2) @(negedge clk);
      rst_n     = 1'b0;
      rx_serial = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("midreset_valid", o_rx_valid, 0);
      check("midreset_busy", o_rx_busy, 0);
      check("midreset_byte", o_rx_byte, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h81, 1'b1, 1'b1, 0);
      end_check("reset_mid_frame");

      // Handshake of the old byte on the same edge as the new stop sample.
      ready_mode = 1'b0;
      rx_ready   = 1'b0;
      send_frame(8'h11, 1'b1, 1'b1, 0);
      repeat (5) @(negedge clk);
      exp_q.push_back(8'h22);
      fork
         send_frame(8'h22, 1'b1, 1'b0, 0);
         begin
            @(negedge clk);
            repeat (3 + HALF + 9 * CPB) @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            #1;
            check("coincident_valid", o_rx_valid, 1);
            check("coincident_byte", o_rx_byte, 8'h22);
         end
      join
      repeat (5) @(negedge clk);
      #1;
      check("coincident_overrun", seen_ovr, exp_ovr);
      drain();
      end_check("coincident");

      // Random bursts with random consumer readiness and occasional bad stop bits.
      for (int burst = 0; burst < 3; burst++) begin
         ready_mode = 1'($urandom_range(0, 1));
         rx_ready   = ready_mode;
         held_full  = 1'b0;
         for (int j = 0; j < 4; j++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, 1'b1, 0);
            repeat ($urandom_range(2, 30)) @(negedge clk);
         end
         drain();
         end_check("random_burst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_stream.md
UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, meaning clock cycles per UART bit (25 MHz / 115200 baud).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port i_rx_serial, input, 1 bit: the asynchronous UART line, idle high.
REQ-005 The block SHALL have port o_rx_byte, output, 8 bits: the received data byte, LSB first on the line.
REQ-006 The block SHALL have port o_rx_valid, output, 1 bit: o_rx_byte holds an undelivered byte.
REQ-007 The block SHALL have port i_rx_ready, input, 1 bit: the consumer accepts the byte.
REQ-008 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-009 The block SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the holding register is full.
REQ-010 The block SHALL have port o_rx_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 i_rx_serial SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized signal (2-cycle input latency).
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 IDLE: on synchronized line = 0, clear the bit counter and go to START.
REQ-014 START: count to (CLKS_PER_BIT-1)/2 (integer division; 108 at default), then resample; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse).
REQ-015 DATA: every CLKS_PER_BIT cycles, sample one bit into a shift register, LSB first; after bit index 7, go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample; 1 -> deliver the byte and go to IDLE; 0 -> pulse o_frame_err, discard the byte and go to WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until the synchronized line = 1 (break / long-low handling), then go to IDLE.
REQ-018 Delivery with o_rx_valid = 0: load o_rx_byte and set o_rx_valid on the next edge after the stop sample.
REQ-019 Delivery with o_rx_valid = 1 and i_rx_ready = 0: keep the old byte, drop the new byte, pulse o_overrun.
REQ-020 Delivery in the same cycle as a handshake (o_rx_valid & i_rx_ready): load the new byte, keep o_rx_valid = 1, no o_overrun.
REQ-021 o_rx_valid SHALL clear on the edge where o_rx_valid & i_rx_ready, unless REQ-020 applies; o_rx_byte SHALL be stable while o_rx_valid = 1.
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reset to 0 on every state change, and never wrap mid-bit.
REQ-023 i_rx_ready while o_rx_valid = 0 SHALL have no effect.

Reset
REQ-024 While i_rst_n = 0 at a clock edge:
- state = IDLE; counters = 0
- o_rx_byte = 8'h00
- o_rx_valid, o_frame_err, o_overrun, o_rx_busy = 0
- synchronizer flops = 1
REQ-025 Reset mid-frame SHALL abandon the frame with no pulses. After release, a line held low SHALL be treated as a new start bit.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state enumeration and the default CLKS_PER_BIT constant; uart_pkg SHALL be reusable by the transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module, uart_sync2 (1-bit, reset value 1).
REQ-028 The implementation SHALL be 120-400 lines of RTL with no latches; all outputs SHALL be registered.

Verification
REQ-029 Serial 8'h3F at 217 clocks/bit with i_rx_ready = 1 -> o_rx_valid, o_rx_byte = 8'h3F; o_rx_valid falls the next cycle.
REQ-030 Bytes 8'hA5 then 8'h5A back-to-back with i_rx_ready = 0 -> o_rx_byte stays 8'hA5; o_overrun pulses once at the second stop sample.
REQ-031 Frame 8'hFF with the stop bit driven 0, then line low for 20 bit times -> one o_frame_err pulse, no o_rx_valid; the next good frame 8'h00 is received correctly.
REQ-032 Line-low glitch of 50 cycles from idle -> state returns to IDLE; no valid, frame-error or overrun pulse.
REQ-033 i_rst_n = 0 at DATA bit 4 of 8'hC3 -> all outputs reset; a subsequent 8'h81 is received correctly.
REQ-034 Stop sample coincident with o_rx_valid & i_rx_ready (old 8'h11, new 8'h22) -> o_rx_byte = 8'h22, o_rx_valid stays 1, no o_overrun.
